onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource, such as the one-hot state datapath, among N requesters.
- Sequenced by a one-hot controller FSM with three states: IDLE, GRANT, RECOVER.
- Grant is one-hot and registered. A per-grant hold counter forces rotation when a requester holds too long.
- Exports an 8-character ASCII state name for waveform and coverage debug.

Parameters:
- N, 3, number of requesters (2..8).
- MAX_HOLD, 4, maximum consecutive GRANT cycles per grant (1..2**CW).
- CW, 3, width of the hold counter.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i set means requester i wants the resource.
- done  input  1  the current owner releases the resource; ignored outside GRANT.
- grant  output  N  one-hot grant, registered; all zero when nobody owns the resource.
- busy  output  1  high when the FSM is in GRANT.
- owner  output  CW  index of the last granted requester.
- hold_cnt  output  CW  GRANT cycles elapsed for the current owner.
- state_str  output  64  ASCII state name, 8 bytes, MSB first, padded with spaces.

Behaviour:
- Reset is synchronous and active-high on clock; it overrides all other inputs.
- Reset values:
  - state = ST_IDLE
  - grant = 0, busy = 0, owner = 0, hold_cnt = 0
  - rotation pointer ptr = 0
  - state_str = "IDLE    "
- State encoding is one-hot: ST_IDLE = 3'b001, ST_GRANT = 3'b010, ST_RECOVER = 3'b100. Next-state decode switches on the set bit.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the first set req bit scanning ptr, ptr+1, ..., wrapping mod N.
  - Next edge: grant = onehot(sel), owner = sel, hold_cnt = 0, state = GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT:
  - Each cycle, release if any of these hold: done == 1, req[owner] == 0, or hold_cnt == MAX_HOLD-1.
  - On release, next edge: grant = 0, state = RECOVER, ptr = (owner+1) mod N, hold_cnt = 0.
  - Otherwise hold_cnt increments by 1, and grant, owner and state are held.
  - Simultaneous release causes (done together with timeout) give a single release; ptr still advances by one.
  - The hold counter never wraps: the timeout release fires first.
- RECOVER:
  - Lasts one cycle with grant = 0, then goes to IDLE unconditionally. req is ignored.
  - Minimum back-to-back turnaround is therefore 2 idle cycles between grants.
- Grant invariants:
  - grant is always zero or one-hot.
  - grant is nonzero only while in GRANT.
  - busy = state[1].
- ptr wrap: if owner == N-1, ptr becomes 0.
- owner holds its value through RECOVER and IDLE until the next grant.
- state_str is registered alongside state: "IDLE    ", "GRANT   ", "RECOVER ".
- Reset asserted mid-GRANT: grant drops to 0 at that edge and ptr returns to 0. Fairness history is discarded.
- An illegal state value (not one-hot) recovers to IDLE with grant = 0 on the next edge.

Decomposition:
- Shared package holds:
  - the state constants ST_IDLE, ST_GRANT, ST_RECOVER;
  - their 64-bit ASCII name constants;
  - the state-vector width, 3.
- One sub-module, rr_pick: combinational rotate-priority selector.
  - Inputs: req[N], ptr[CW].
  - Outputs: sel[CW], any.
  - Instantiated once. The FSM, counters and registers stay in the top module.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles, req = 0 for 5 cycles -> grant = 000, state_str = "IDLE    ", busy = 0 throughout.
- Single requester with done: req = 3'b010 from cycle 0, done = 1 in the 3rd GRANT cycle -> grant = 010 one cycle after req. Then RECOVER, IDLE, and grant = 010 again; ptr = 2.
- Rotation: req = 3'b111 held, done never asserted -> grants in order 001, 010, 100, 001. Each grant lasts exactly MAX_HOLD = 4 cycles, with hold_cnt 0..3. Grants are separated by 2 zero-grant cycles.
- Requester drops: req = 3'b101, owner 0 drops req[0] after 1 GRANT cycle -> release, then grant = 100 two cycles later.
- Simultaneous done and timeout: done = 1 exactly when hold_cnt = 3 -> single RECOVER cycle; ptr advances by one only.
- Reset mid-GRANT: reset pulsed while grant = 100 -> grant = 000 at that edge, ptr = 0. With req = 3'b111 after reset, the next grant is 001.

Source files
------------

// File: rtl/onehot_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter_pkg
//   Shared definitions for the one-hot round-robin arbiter:
//   - SW      : width of the one-hot controller state vector
//   - NAME_W  : width of the exported ASCII state name (8 characters)
//   - state_e : one-hot controller states IDLE / GRANT / RECOVER
//   - NAME_*  : space-padded ASCII names, MSB-first, one per state
// ---------------------------------------------------------------------------
package onehot_rr_arbiter_pkg;

  localparam int SW     = 3;
  localparam int NAME_W = 64;

  typedef enum logic [SW-1:0] {
    ST_IDLE    = 3'b001,
    ST_GRANT   = 3'b010,
    ST_RECOVER = 3'b100
  } state_e;

  localparam logic [NAME_W-1:0] NAME_IDLE    = "IDLE    ";
  localparam logic [NAME_W-1:0] NAME_GRANT   = "GRANT   ";
  localparam logic [NAME_W-1:0] NAME_RECOVER = "RECOVER ";

endpackage : onehot_rr_arbiter_pkg

// File: rtl/onehot_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter_if
//   Request/grant bundle between the requesters and the arbiter.
//   req       : N   request vector, bit i = requester i wants the resource
//   done      : 1   current owner releases the resource
//   grant     : N   registered one-hot grant, zero when nobody owns it
//   busy      : 1   arbiter is in GRANT
//   owner     : CW  index of the last granted requester
//   hold_cnt  : CW  GRANT cycles elapsed for the current owner
//   state_str : 64  ASCII state name for debug
//   modport master : requester side (drives req/done)
//   modport slave  : arbiter side (drives grant and status)
// ---------------------------------------------------------------------------
interface onehot_rr_arbiter_if
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 3
);

  logic [N-1:0]      req;
  logic              done;
  logic [N-1:0]      grant;
  logic              busy;
  logic [CW-1:0]     owner;
  logic [CW-1:0]     hold_cnt;
  logic [NAME_W-1:0] state_str;

  modport master (
    output req, done,
    input  grant, busy, owner, hold_cnt, state_str
  );

  modport slave (
    input  req, done,
    output grant, busy, owner, hold_cnt, state_str
  );

endinterface : onehot_rr_arbiter_if

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority selector. Scans req starting at ptr,
//   then ptr+1, ... wrapping modulo N, and returns the first set index.
//   req : N   request vector
//   ptr : CW  highest-priority index for this scan (must be < N)
//   sel : CW  index of the winning requester (0 when none)
//   any : 1   at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] sel,
  output logic          any
);

  always_comb begin
    int           idx;
    logic [N-1:0] shifted;
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sel     = '0;
    any     = 1'b0;
    idx     = 0;
    shifted = '0;
    for (int i = 0; i < N; i++) begin
      idx     = (int'(ptr) + i) % N;
      // Shift instead of a variable bit-select keeps index widths clean.
      shifted = req >> idx;
      if (!any && shifted[0]) begin
        sel = CW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter
//   Round-robin arbiter sharing one resource among N requesters, sequenced
//   by a one-hot IDLE -> GRANT -> RECOVER controller. Grant is registered
//   and one-hot; a per-grant hold counter forces rotation after MAX_HOLD
//   GRANT cycles.
//   clock : sole clock, rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : onehot_rr_arbiter_if.slave (req/done in, grant/status out)
// ---------------------------------------------------------------------------
module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  onehot_rr_arbiter_if.slave   bus
);

  // Elaboration-time parameter sanity.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("onehot_rr_arbiter: N must be in 2..8");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > (1 << CW)) begin : g_bad_hold
    $error("onehot_rr_arbiter: MAX_HOLD must be in 1..2**CW");
  end
  if ((1 << CW) < N) begin : g_bad_cw
    $error("onehot_rr_arbiter: CW too narrow to index N requesters");
  end

  state_e        state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] sel;
  logic          any;
  logic          owner_req;
  logic          timeout;
  logic          release_now;
  logic [CW-1:0] next_ptr;
  logic [N-1:0]  sel_onehot;

  rr_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // Release decode for the GRANT state: owner done, owner dropped its
  // request, or the hold budget is spent. Any combination is one release.
  assign owner_req   = |(bus.req & (N'(1) << bus.owner));
  assign timeout     = (bus.hold_cnt == CW'(MAX_HOLD - 1));
  assign release_now = bus.done || !owner_req || timeout;
  assign next_ptr    = (bus.owner == CW'(N - 1)) ? '0 : bus.owner + CW'(1);
  assign sel_onehot  = N'(1) << sel;

  assign bus.busy    = state[1];

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.state_str <= NAME_IDLE;
      bus.grant     <= '0;
      bus.owner     <= '0;
      bus.hold_cnt  <= '0;
      ptr           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state         <= ST_GRANT;
            bus.state_str <= NAME_GRANT;
            bus.grant     <= sel_onehot;
            bus.owner     <= sel;
            bus.hold_cnt  <= '0;
          end
        end

        ST_GRANT: begin
          if (release_now) begin
            state         <= ST_RECOVER;
            bus.state_str <= NAME_RECOVER;
            bus.grant     <= '0;
            bus.hold_cnt  <= '0;
            ptr           <= next_ptr;
          end else begin
            // Timeout releases before the counter can reach 2**CW, so
            // this increment never wraps.
            bus.hold_cnt  <= bus.hold_cnt + CW'(1);
          end
        end

        ST_RECOVER: begin
          // Single dead cycle; req is deliberately ignored here.
          state         <= ST_IDLE;
          bus.state_str <= NAME_IDLE;
          bus.grant     <= '0;
        end

        default: begin
          // Non-one-hot state: fall back to a clean IDLE with no grant.
          state         <= ST_IDLE;
          bus.state_str <= NAME_IDLE;
          bus.grant     <= '0;
          bus.hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule : onehot_rr_arbiter

// File: tb/tb_onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onehot_rr_arbiter
//   Directed self-checking bench for onehot_rr_arbiter (N=3, MAX_HOLD=4,
//   CW=3). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_onehot_rr_arbiter;
  import onehot_rr_arbiter_pkg::*;

  localparam int N        = 3;
  localparam int MAX_HOLD = 4;
  localparam int CW       = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  onehot_rr_arbiter_if #(.N(N), .CW(CW)) bus ();

  onehot_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Checks the full visible status in one call.
  task automatic check_all(input string tag, input logic [N-1:0] g,
                           input logic b, input logic [CW-1:0] o,
                           input logic [CW-1:0] h, input logic [63:0] s);
    check({tag, ".grant"},     {61'd0, bus.grant}, {61'd0, g});
    check({tag, ".busy"},      {63'd0, bus.busy},  {63'd0, b});
    check({tag, ".owner"},     {61'd0, bus.owner}, {61'd0, o});
    check({tag, ".hold_cnt"},  {61'd0, bus.hold_cnt}, {61'd0, h});
    check({tag, ".state_str"}, bus.state_str, s);
  endtask

  initial begin
    logic [N-1:0] rot_seq [4];
    rot_seq[0] = 3'b001;
    rot_seq[1] = 3'b010;
    rot_seq[2] = 3'b100;
    rot_seq[3] = 3'b001;

    bus.req  = '0;
    bus.done = 1'b0;

    // --- Reset then idle -------------------------------------------------
    reset = 1'b1;
    tick(); tick();
    check_all("reset", 3'b000, 1'b0, 3'd0, 3'd0, "IDLE    ");
    check("reset.ptr", {61'd0, dut.ptr}, 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 3) bus.done = 1'b1;   // done must be ignored outside GRANT
      tick();
      check("idle.grant", {61'd0, bus.grant}, 64'd0);
      check("idle.busy",  {63'd0, bus.busy},  64'd0);
      check("idle.str",   bus.state_str, "IDLE    ");
    end
    bus.done = 1'b0;

    // --- Single requester with done --------------------------------------
    bus.req = 3'b010;
    tick();
    check_all("single.g0", 3'b010, 1'b1, 3'd1, 3'd0, "GRANT   ");
    tick();
    check_all("single.g1", 3'b010, 1'b1, 3'd1, 3'd1, "GRANT   ");
    tick();
    check_all("single.g2", 3'b010, 1'b1, 3'd1, 3'd2, "GRANT   ");
    bus.done = 1'b1;                  // released in 3rd GRANT cycle
    tick();
    check_all("single.rec", 3'b000, 1'b0, 3'd1, 3'd0, "RECOVER ");
    check("single.ptr", {61'd0, dut.ptr}, 64'd2);
    bus.done = 1'b0;
    tick();
    check_all("single.idle", 3'b000, 1'b0, 3'd1, 3'd0, "IDLE    ");
    tick();
    check_all("single.regrant", 3'b010, 1'b1, 3'd1, 3'd0, "GRANT   ");
    bus.req = '0;                     // owner drops, release
    tick();
    check("single.drop.grant", {61'd0, bus.grant}, 64'd0);
    tick();

    // --- Rotation with timeout -------------------------------------------
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < MAX_HOLD; h++) begin
        tick();
        check("rot.grant", {61'd0, bus.grant}, {61'd0, rot_seq[k]});
        check("rot.hold",  {61'd0, bus.hold_cnt}, 64'(h));
        check("rot.busy",  {63'd0, bus.busy}, 64'd1);
      end
      tick();
      check("rot.gap1", {61'd0, bus.grant}, 64'd0);
      check("rot.gap1.str", bus.state_str, "RECOVER ");
      tick();
      check("rot.gap2", {61'd0, bus.grant}, 64'd0);
      check("rot.gap2.str", bus.state_str, "IDLE    ");
    end
    check("rot.ptr", {61'd0, dut.ptr}, 64'd1);

    // --- Requester drops its request -------------------------------------
    bus.req = '0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    bus.req = 3'b101;
    tick();
    check_all("drop.g0", 3'b001, 1'b1, 3'd0, 3'd0, "GRANT   ");
    bus.req = 3'b100;
    tick();
    check_all("drop.rec", 3'b000, 1'b0, 3'd0, 3'd0, "RECOVER ");
    check("drop.ptr", {61'd0, dut.ptr}, 64'd1);
    tick();
    check("drop.idle", {61'd0, bus.grant}, 64'd0);
    tick();
    check_all("drop.g2", 3'b100, 1'b1, 3'd2, 3'd0, "GRANT   ");

    // --- Simultaneous done and timeout (also ptr wrap) -------------------
    tick();
    tick();
    tick();
    check("sim.hold3", {61'd0, bus.hold_cnt}, 64'd3);
    bus.done = 1'b1;
    tick();
    check_all("sim.rec", 3'b000, 1'b0, 3'd2, 3'd0, "RECOVER ");
    check("sim.ptr", {61'd0, dut.ptr}, 64'd0);
    bus.done = 1'b0;
    tick();
    check_all("sim.idle", 3'b000, 1'b0, 3'd2, 3'd0, "IDLE    ");
    check("sim.ptr2", {61'd0, dut.ptr}, 64'd0);
    tick();
    check_all("sim.regrant", 3'b100, 1'b1, 3'd2, 3'd0, "GRANT   ");

    // --- Reset mid-GRANT --------------------------------------------------
    bus.req = 3'b111;
    reset   = 1'b1;
    tick();
    check_all("rstmid", 3'b000, 1'b0, 3'd0, 3'd0, "IDLE    ");
    check("rstmid.ptr", {61'd0, dut.ptr}, 64'd0);
    reset = 1'b0;
    tick();
    check_all("rstmid.next", 3'b001, 1'b1, 3'd0, 3'd0, "GRANT   ");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_onehot_rr_arbiter
